alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter in front of a shared combinational ALU
// Operands are latched at grant, so the ALU never sees live requester inputs.
module alu_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_last_grant;
  logic [3:0]  r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_rsp_result;
  logic        r_rsp_id;
  logic        r_rsp_err;
  logic        w_grant1;
  logic        w_accept;
  logic        w_legal;

  // req1 wins when alone, or when both are valid and round-robin says it is its turn
  assign w_grant1 = req1_valid && (!req0_valid || ((RR_EN != 0) && !r_last_grant));
  assign w_accept = req0_ready || req1_ready;

  always_comb begin
    w_next_state = r_state;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (r_state)
      IDLE: begin
        req0_ready = rst_n && req0_valid && !w_grant1;
        req1_ready = rst_n && w_grant1;
        if (req0_ready || req1_ready) w_next_state = EXEC;
      end
      EXEC:    w_next_state = RESP;
      RESP:    if (rsp_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_legal = 1'b0;
    case (r_op)
      4'b0000, 4'b1000, 4'b0111, 4'b0110, 4'b0100,
      4'b0001, 4'b0101, 4'b1101, 4'b0010, 4'b0011: w_legal = 1'b1;
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_op         <= 4'b0000;
      r_a          <= 32'd0;
      r_b          <= 32'd0;
      r_rsp_result <= 32'd0;
      r_rsp_id     <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_last_grant <= w_grant1;
        r_op         <= w_grant1 ? req1_op : req0_op;
        r_a          <= w_grant1 ? req1_a  : req0_a;
        r_b          <= w_grant1 ? req1_b  : req0_b;
      end
      if (r_state == EXEC) begin
        r_rsp_id     <= r_last_grant;
        r_rsp_err    <= !w_legal;
        r_rsp_result <= w_legal ? alu_result : 32'd0;
      end
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_op     = r_op;
  assign rsp_valid  = (r_state == RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_err    = r_rsp_err;

endmodule
